// File: rtl/uart_pkg.sv
// uart_pkg: shared types, constants and helpers for the UART blocks.
// Holds the transmitter FSM state type, parity modes and bit-period math.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_tx_state_t;

  localparam int unsigned PAR_NONE = 0;
  localparam int unsigned PAR_EVEN = 1;
  localparam int unsigned PAR_ODD  = 2;

  // Clock cycles per serial bit (integer division).
  function automatic int unsigned bit_cycles(
    input int unsigned fclk,
    input int unsigned baud
  );
    return fclk / baud;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// uart_bit_timer: bit-period down-counter, shared by UART tx and rx.
// Ports: clk_i, rst_i (async high), load_i (reload), clear_i (to 0),
//        bit_end_o (high while the count is 0, i.e. last bit cycle).
module uart_bit_timer #(
  parameter int unsigned BIT_CYC = 434
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic load_i,
  input  logic clear_i,
  output logic bit_end_o
);

  localparam int unsigned W = (BIT_CYC > 1) ? $clog2(BIT_CYC) : 1;
  localparam logic [W-1:0] RELOAD = W'(BIT_CYC - 1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  assign bit_end_o = (cnt_q == '0);

  // Load wins over clear so an accept in the idle cycle is not lost;
  // otherwise the counter free-runs and auto-reloads at each bit end.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = RELOAD;
    end else if (clear_i) begin
      cnt_d = '0;
    end else if (bit_end_o) begin
      cnt_d = RELOAD;
    end else begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// uart_tx: UART transmitter, start + 8 data (LSB first) + parity + stop.
// Ports: clk50m, rst (async high), tx_data[7:0], tx_start in;
//        tx (registered line), tx_busy, tx_done (pulse), tx_idle out.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned fclk      = 50_000_000,
  parameter int unsigned baud      = 115_200,
  parameter int unsigned PARITY    = 0,
  parameter int unsigned STOP_BITS = 1
) (
  input  logic       clk50m,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  output logic       tx,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_idle
);

  localparam int unsigned BIT_CYC = bit_cycles(fclk, baud);
  localparam bit HAS_PAR = (PARITY != PAR_NONE);

  if (PARITY > PAR_ODD) begin : g_bad_parity
    $error("uart_tx: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
    $error("uart_tx: STOP_BITS must be 1 or 2");
  end
  if (BIT_CYC < 1) begin : g_bad_baud
    $error("uart_tx: fclk must be at least baud");
  end

  uart_tx_state_t state_q, state_d;
  logic [7:0] shift_q, shift_d;
  logic [2:0] bcnt_q, bcnt_d;
  logic       scnt_q, scnt_d;
  logic       par_q, par_d;
  logic       tx_q, tx_d;
  logic       load;
  logic       clear;
  logic       bit_end;
  logic       done;
  logic       last_stop;

  uart_bit_timer #(
    .BIT_CYC(BIT_CYC)
  ) u_timer (
    .clk_i    (clk50m),
    .rst_i    (rst),
    .load_i   (load),
    .clear_i  (clear),
    .bit_end_o(bit_end)
  );

  // Timer rests at zero whenever the FSM is headed for IDLE.
  assign clear     = (state_d == IDLE);
  assign last_stop = (STOP_BITS == 1) || scnt_q;

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    bcnt_d  = bcnt_q;
    scnt_d  = scnt_q;
    par_d   = par_q;
    load    = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (tx_start) begin
          shift_d = tx_data;
          par_d   = (PARITY == PAR_ODD) ? ~^tx_data : ^tx_data;
          bcnt_d  = 3'd0;
          scnt_d  = 1'b0;
          load    = 1'b1;
          state_d = START;
        end
      end
      START: begin
        if (bit_end) state_d = DATA;
      end
      DATA: begin
        if (bit_end) begin
          shift_d = {1'b0, shift_q[7:1]};
          bcnt_d  = bcnt_q + 3'd1;
          if (bcnt_q == 3'd7) begin
            state_d = HAS_PAR ? uart_pkg::PARITY : STOP;
          end
        end
      end
      uart_pkg::PARITY: begin
        if (bit_end) state_d = STOP;
      end
      STOP: begin
        if (bit_end) begin
          if (last_stop) begin
            done    = 1'b1;
            state_d = IDLE;
          end else begin
            scnt_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Line value for the upcoming cycle, so tx comes straight off a flop.
  always_comb begin
    tx_d = 1'b1;
    unique case (state_d)
      START:            tx_d = 1'b0;
      DATA:             tx_d = shift_d[0];
      uart_pkg::PARITY: tx_d = par_d;
      default:          tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk50m or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      shift_q <= '0;
      bcnt_q  <= '0;
      scnt_q  <= 1'b0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      bcnt_q  <= bcnt_d;
      scnt_q  <= scnt_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
    end
  end

  assign tx      = tx_q;
  assign tx_busy = (state_q != IDLE);
  assign tx_idle = (state_q == IDLE);
  assign tx_done = done;

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed self-checking bench for uart_tx at BIT_CYC=10.
// Four instances cover no/even/odd parity and two stop bits.
module tb_uart_tx;

  localparam int FCLK = 1_000_000;
  localparam int BAUD = 100_000;
  localparam int BC   = 10;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] d    [4];
  logic       s    [4];
  logic       tx   [4];
  logic       busy [4];
  logic       done [4];
  logic       idle [4];

  int passed = 0;
  int fails  = 0;
  int total  = 0;

  always #5 clk = ~clk;

  uart_tx #(.fclk(FCLK), .baud(BAUD), .PARITY(0), .STOP_BITS(1)) u0 (
    .clk50m(clk), .rst(rst), .tx_data(d[0]), .tx_start(s[0]),
    .tx(tx[0]), .tx_busy(busy[0]), .tx_done(done[0]), .tx_idle(idle[0])
  );
  uart_tx #(.fclk(FCLK), .baud(BAUD), .PARITY(1), .STOP_BITS(1)) u1 (
    .clk50m(clk), .rst(rst), .tx_data(d[1]), .tx_start(s[1]),
    .tx(tx[1]), .tx_busy(busy[1]), .tx_done(done[1]), .tx_idle(idle[1])
  );
  uart_tx #(.fclk(FCLK), .baud(BAUD), .PARITY(2), .STOP_BITS(1)) u2 (
    .clk50m(clk), .rst(rst), .tx_data(d[2]), .tx_start(s[2]),
    .tx(tx[2]), .tx_busy(busy[2]), .tx_done(done[2]), .tx_idle(idle[2])
  );
  uart_tx #(.fclk(FCLK), .baud(BAUD), .PARITY(0), .STOP_BITS(2)) u3 (
    .clk50m(clk), .rst(rst), .tx_data(d[3]), .tx_start(s[3]),
    .tx(tx[3]), .tx_busy(busy[3]), .tx_done(done[3]), .tx_idle(idle[3])
  );

  task automatic chk(input string tag, input int i, input int c,
                     input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s u%0d cyc=%0d observed=%0h expected=%0h",
             tag, i, c, obs, exp);
    end
  endtask

  // Expected line level in a given bit slot of a frame.
  function automatic logic model_bit(input logic [7:0] b, input int par,
                                     input int slot);
    int ones;
    ones = $countones(b);
    if (slot == 0) return 1'b0;
    if (slot <= 8) return b[slot-1];
    if (par != 0 && slot == 9) begin
      if (par == 1) return (ones % 2 == 1);
      return (ones % 2 == 0);
    end
    return 1'b1;
  endfunction

  // One request: leaves the bench in cycle 1 after the accept edge.
  task automatic send(input int i, input logic [7:0] b, input logic keep);
    @(posedge clk); #1;
    d[i] = b;
    s[i] = 1'b1;
    @(posedge clk); #1;
    s[i] = keep;
  endtask

  // Checks cycles 1..len+1 of a frame. At cycle inj: mode 0 drops start,
  // mode 1 pulses start for one cycle, mode 2 holds start high; data=nd.
  task automatic frame(input int i, input logic [7:0] b, input int par,
                       input int stops, input int inj, input int mode,
                       input logic [7:0] nd);
    int len;
    logic e;
    len = BC * (10 + ((par != 0) ? 1 : 0) + (stops - 1));
    for (int c = 1; c <= len + 1; c++) begin
      @(negedge clk);
      e = (c <= len) ? model_bit(b, par, (c - 1) / BC) : 1'b1;
      chk("tx", i, c, tx[i], e);
      chk("busy", i, c, busy[i], (c <= len));
      chk("idle", i, c, idle[i], (c > len));
      chk("done", i, c, done[i], (c == len));
      if (c == inj) begin
        d[i] = nd;
        s[i] = (mode != 0);
      end
      if (c == inj + 1 && mode == 1) s[i] = 1'b0;
    end
  endtask

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      d[i] = 8'h00;
      s[i] = 1'b0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      chk("rst_tx", i, 0, tx[i], 1'b1);
      chk("rst_busy", i, 0, busy[i], 1'b0);
      chk("rst_done", i, 0, done[i], 1'b0);
      chk("rst_idle", i, 0, idle[i], 1'b1);
    end
    @(posedge clk); #1;
    rst = 1'b0;

    // Basic frame, no parity, one stop bit.
    send(0, 8'h55, 1'b0);
    frame(0, 8'h55, 0, 1, 0, 0, 8'h00);

    // Even and odd parity on 0x07.
    send(1, 8'h07, 1'b0);
    frame(1, 8'h07, 1, 1, 0, 0, 8'h00);
    send(2, 8'h07, 1'b0);
    frame(2, 8'h07, 2, 1, 0, 0, 8'h00);

    // Two stop bits.
    send(3, 8'hFF, 1'b0);
    frame(3, 8'hFF, 0, 2, 0, 0, 8'h00);

    // Start pulse while busy with new data: ignored.
    send(0, 8'hA5, 1'b0);
    frame(0, 8'hA5, 0, 1, 40, 1, 8'h3C);

    // Held start: back-to-back frames with one idle cycle between.
    send(0, 8'h00, 1'b1);
    frame(0, 8'h00, 0, 1, 40, 2, 8'hFF);
    @(posedge clk); #1;
    frame(0, 8'hFF, 0, 1, 40, 2, 8'h5A);
    @(posedge clk); #1;
    frame(0, 8'h5A, 0, 1, 40, 2, 8'hC3);
    @(posedge clk); #1;
    frame(0, 8'hC3, 0, 1, 40, 0, 8'h00);

    // Reset in the middle of a frame.
    send(0, 8'hA5, 1'b0);
    repeat (33) @(posedge clk);
    #1;
    chk("pre_rst_busy", 0, 35, busy[0], 1'b1);
    chk("pre_rst_tx", 0, 35, tx[0], model_bit(8'hA5, 0, 3));
    rst = 1'b1;
    #1;
    chk("mid_rst_tx", 0, 35, tx[0], 1'b1);
    chk("mid_rst_busy", 0, 35, busy[0], 1'b0);
    chk("mid_rst_done", 0, 35, done[0], 1'b0);
    chk("mid_rst_idle", 0, 35, idle[0], 1'b1);
    for (int c = 36; c < 39; c++) begin
      @(negedge clk);
      chk("rst_hold_tx", 0, c, tx[0], 1'b1);
      chk("rst_hold_done", 0, c, done[0], 1'b0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("post_rst_done", 0, c, done[0], 1'b0);
      chk("post_rst_tx", 0, c, tx[0], 1'b1);
    end
    send(0, 8'h3C, 1'b0);
    frame(0, 8'h3C, 0, 1, 0, 0, 8'h00);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
